// File: rtl/fixed_point_pkg.sv
// Shared Q9.8 fixed-point definitions used by the divider and the Booth multiplier.
package fixed_point_pkg;

  localparam int WIDTH = 18;
  localparam int FRAC  = 8;
  localparam int QBITS = WIDTH + FRAC;

  localparam logic [WIDTH-1:0] Q_MAX_POS = 18'h1FFFF;
  localparam logic [WIDTH-1:0] Q_MIN_NEG = 18'h20000;
  localparam logic [WIDTH-1:0] Q_ONE     = 18'h00100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Unsigned magnitude of a two's complement value; -2^17 maps to 2^17, which
  // still fits WIDTH bits when read as unsigned.
  function automatic logic [WIDTH-1:0] q_mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/fixed_point_divider_div_restore_step.sv
// One radix-2 restoring division step: shift a numerator bit into the
// remainder, trial-subtract the divisor magnitude, keep or restore.
module div_restore_step
  import fixed_point_pkg::*;
(
  input  logic [WIDTH:0] rem_in,
  input  logic           num_bit,
  input  logic [WIDTH:0] dmag,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_in, num_bit};
    diff    = shifted[WIDTH:0] - dmag;
    if (shifted >= {1'b0, dmag}) begin
      rem_out = diff;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative signed Q9.8 divider, one quotient bit per clock with start/busy/done.
// Define FIXED_POINT_DIVIDER_ROUND_EN for one extra bit and half-away-from-zero rounding.
module fixed_point_divider
  import fixed_point_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output div_state_t       fsm_state
);

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  localparam int NITER = QBITS + 1;
`else
  localparam int NITER = QBITS;
`endif
  localparam int CW = $clog2(NITER + 1);
  localparam logic [NITER-1:0] POS_LIM = NITER'((2 ** (WIDTH - 1)) - 1);
  localparam logic [NITER-1:0] NEG_LIM = NITER'(2 ** (WIDTH - 1));

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [NITER-1:0] num_sr;
  logic [NITER-1:0] qmag;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   dmag;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [NITER-1:0] rmag;
  logic [WIDTH-1:0] res_q;
  logic             res_z;
  logic             res_neg;

  assign fsm_state = state;

  div_restore_step u_step (
    .rem_in  (rem),
    .num_bit (num_sr[NITER-1]),
    .dmag    (dmag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  assign rmag = {1'b0, qmag[NITER-1:1]} + NITER'(qmag[0]);
`else
  assign rmag = qmag;
`endif

  // Sign, negation and saturation applied to the finished magnitude.
  always_comb begin
    res_neg = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
    res_z   = 1'b0;
    res_q   = '0;
    if (b_reg == '0) begin
      res_z = 1'b1;
      res_q = a_reg[WIDTH-1] ? Q_MIN_NEG : Q_MAX_POS;
    end else if (!res_neg) begin
      res_q = (rmag > POS_LIM) ? Q_MAX_POS : rmag[WIDTH-1:0];
    end else begin
      res_q = (rmag > NEG_LIM) ? Q_MIN_NEG : (~rmag[WIDTH-1:0] + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      num_sr      <= '0;
      qmag        <= '0;
      rem         <= '0;
      dmag        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // The first CALC cycle forms the magnitudes; the rest each retire one bit.
          if (cnt == '0) begin
            num_sr <= {q_mag(a_reg), {(NITER - WIDTH){1'b0}}};
            dmag   <= {1'b0, q_mag(b_reg)};
            rem    <= '0;
            qmag   <= '0;
          end else begin
            num_sr <= {num_sr[NITER-2:0], 1'b0};
            rem    <= rem_next;
            qmag   <= {qmag[NITER-2:0], q_bit};
          end
          if (cnt == CW'(NITER)) begin
            state <= FINISH;
          end
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          quotient    <= res_q;
          div_by_zero <= res_z;
          done        <= 1'b1;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
